fu_sequencer: RTL and testbench



---
 rtl/fu_sequencer.sv | 130 +++++++++++++
 tb/tb_fu_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_sequencer.sv
// Issue controller for the 16-bit function unit: 8x16 register file, valid/ready instruction intake,
// registered operand drive and writeback with V/C/N/Z status. Optional macro: FU_SEQUENCER_PRESERVE_VC_EN.
module fu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  instr_op,
  input  logic [2:0]  instr_dst,
  input  logic [2:0]  instr_srca,
  input  logic [2:0]  instr_srcb,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [3:0]  fu_fs,
  output logic [15:0] fu_opa,
  output logic [15:0] fu_opb,
  input  logic [15:0] fu_result,
  input  logic        fu_v,
  input  logic        fu_c,
  input  logic        fu_n,
  input  logic        fu_z,
  output logic        flag_v,
  output logic        flag_c,
  output logic        flag_n,
  output logic        flag_z,
  output logic        done,
  output logic        err,
  output logic [15:0] done_result
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t      state, state_nxt;
  logic [15:0] rf [8];
  logic [2:0]  dst_p0;
  logic        accept, retire, legal;

  function automatic logic is_legal(input logic [3:0] fs);
    return fs <= 4'b1100;
  endfunction

  assign legal   = is_legal(fu_fs);
  assign rd_data = rf[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A pending load blocks intake, so the load always wins the IDLE cycle.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    accept      = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = !ld_en;
        if (instr_valid && !ld_en) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        retire    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (state == IDLE && ld_en) begin
      rf[ld_addr] <= ld_data;
    end else if (retire && legal) begin
      rf[dst_p0] <= fu_result;
    end
  end

  // Operand stage: captured at accept, held steady until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_fs  <= '0;
      fu_opa <= '0;
      fu_opb <= '0;
      dst_p0 <= '0;
    end else if (accept) begin
      fu_fs  <= instr_op;
      fu_opa <= rf[instr_srca];
      fu_opb <= rf[instr_srcb];
      dst_p0 <= instr_dst;
    end
  end

  // Writeback stage: status and retirement pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_v      <= 1'b0;
      flag_c      <= 1'b0;
      flag_n      <= 1'b0;
      flag_z      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      done_result <= '0;
    end else begin
      done <= retire;
      err  <= retire && !legal;
      if (retire && legal) begin
        done_result <= fu_result;
        flag_n      <= fu_n;
        flag_z      <= fu_z;
`ifdef FU_SEQUENCER_PRESERVE_VC_EN
        if (fu_fs[3]) begin
          flag_v <= fu_v;
          flag_c <= fu_c;
        end
`else
        flag_v <= fu_v;
        flag_c <= fu_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fu_sequencer.sv
// Scoreboard bench for fu_sequencer: directed instructions against a small function-unit stand-in.
module tb_fu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_dst, instr_srca, instr_srcb;
  logic        ld_en;
  logic [2:0]  ld_addr, rd_addr;
  logic [15:0] ld_data, rd_data;
  logic [3:0]  fu_fs;
  logic [15:0] fu_opa, fu_opb, fu_result;
  logic        fu_v, fu_c, fu_n, fu_z;
  logic        flag_v, flag_c, flag_n, flag_z;
  logic        done, err;
  logic [15:0] done_result;
  logic [16:0] fu_sum;

  typedef struct packed {
    logic        e;
    logic [15:0] res;
    logic [3:0]  fl;   // {V,C,N,Z}
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

`ifdef FU_SEQUENCER_PRESERVE_VC_EN
  localparam logic [3:0] FL_MULT8 = 4'b0100;
  localparam logic [3:0] FL_AND   = 4'b1000;
`else
  localparam logic [3:0] FL_MULT8 = 4'b0000;
  localparam logic [3:0] FL_AND   = 4'b0000;
`endif

  always #5 clk = ~clk;

  fu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_dst(instr_dst),
    .instr_srca(instr_srca), .instr_srcb(instr_srcb),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .fu_fs(fu_fs), .fu_opa(fu_opa), .fu_opb(fu_opb),
    .fu_result(fu_result), .fu_v(fu_v), .fu_c(fu_c), .fu_n(fu_n), .fu_z(fu_z),
    .flag_v(flag_v), .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z),
    .done(done), .err(err), .done_result(done_result)
  );

  // Function unit stand-in covering the ops used here; other codes return all-ones garbage.
  always_comb begin
    fu_sum    = '0;
    fu_result = '0;
    fu_v      = 1'b0;
    fu_c      = 1'b0;
    case (fu_fs)
      4'b1000: begin
        fu_sum    = {1'b0, fu_opa} + {1'b0, fu_opb};
        fu_result = fu_sum[15:0];
        fu_c      = fu_sum[16];
        fu_v      = (fu_opa[15] == fu_opb[15]) && (fu_sum[15] != fu_opa[15]);
      end
      4'b1001: begin
        fu_sum    = {1'b0, fu_opa} + {1'b0, ~fu_opb} + 17'd1;
        fu_result = fu_sum[15:0];
        fu_c      = fu_sum[16];
        fu_v      = (fu_opa[15] != fu_opb[15]) && (fu_sum[15] != fu_opa[15]);
      end
      4'b0011: fu_result = fu_opa & fu_opb;
      4'b0110: fu_result = {fu_opb[12:0], 3'b000};
      default: begin
        fu_result = 16'hFFFF;
        fu_v      = 1'b1;
        fu_c      = 1'b1;
      end
    endcase
    fu_n = fu_result[15];
    fu_z = (fu_result == 16'h0000);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every retirement pops one expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          mon_e = q.pop_front();
          chk("err", {15'd0, err}, {15'd0, mon_e.e});
          chk("done_result", done_result, mon_e.res);
          chk("flags_vcnz", {12'd0, flag_v, flag_c, flag_n, flag_z}, {12'd0, mon_e.fl});
        end
      end else if (err) begin
        checks++;
        errors++;
        $display("FAIL err_without_done actual=1 required=0");
      end
    end
  end

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic check_rf(input logic [2:0] a, input logic [15:0] req);
    @(negedge clk);
    rd_addr = a;
    #1 chk($sformatf("rf%0d", a), rd_data, req);
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] d, input logic [2:0] a,
                       input logic [2:0] b, input logic e, input logic [15:0] res,
                       input logic [3:0] fl, input logic do_ld, input logic [2:0] la,
                       input logic [15:0] ldd);
    int n;
    instr_op = op; instr_dst = d; instr_srca = a; instr_srcb = b;
    instr_valid = 1'b1;
    q.push_back('{e: e, res: res, fl: fl});
    if (do_ld) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ldd;
      #1 chk("ready_during_load", {15'd0, instr_ready}, 16'd0);
      @(posedge clk); #1;
      ld_en = 1'b0;
    end
    n = 0;
    #1;
    while (!instr_ready && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
      instr_valid = 1'b0;
      void'(q.pop_back());
      return;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk); #1;
    chk("done_early", {15'd0, done}, 16'd0);
    chk("ready_in_exec", {15'd0, instr_ready}, 16'd0);
    @(negedge clk); #1;
    chk("done_pulse", {15'd0, done}, 16'd1);
    chk("ready_after", {15'd0, instr_ready}, 16'd1);
    chk("fu_fs_hold", {12'd0, fu_fs}, {12'd0, op});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_dst = '0;
    instr_srca = '0; instr_srcb = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    #12;
    chk("rst_ready", {15'd0, instr_ready}, 16'd1);
    chk("rst_done", {14'd0, done, err}, 16'd0);
    chk("rst_fu", fu_opa | fu_opb | {12'd0, fu_fs}, 16'd0);
    chk("rst_done_result", done_result, 16'd0);
    chk("rst_flags", {12'd0, flag_v, flag_c, flag_n, flag_z}, 16'd0);
    chk("rst_rf0", rd_data, 16'd0);
    @(negedge clk); rst_n = 1'b1;

    load(3'd1, 16'h7FFF);
    load(3'd2, 16'h0001);
    check_rf(3'd1, 16'h7FFF);

    issue(4'b1000, 3'd3, 3'd1, 3'd2, 1'b0, 16'h8000, 4'b1010, 1'b0, 3'd0, 16'h0);
    check_rf(3'd3, 16'h8000);
    issue(4'b1001, 3'd4, 3'd1, 3'd1, 1'b0, 16'h0000, 4'b0101, 1'b0, 3'd0, 16'h0);
    check_rf(3'd4, 16'h0000);

    load(3'd5, 16'h0003);
    issue(4'b0110, 3'd6, 3'd0, 3'd5, 1'b0, 16'h0018, FL_MULT8, 1'b0, 3'd0, 16'h0);
    issue(4'b1000, 3'd0, 3'd6, 3'd6, 1'b0, 16'h0030, 4'b0000, 1'b0, 3'd0, 16'h0);
    check_rf(3'd6, 16'h0018);
    check_rf(3'd0, 16'h0030);

    issue(4'b1000, 3'd3, 3'd1, 3'd2, 1'b0, 16'h8000, 4'b1010, 1'b0, 3'd0, 16'h0);
    issue(4'b0011, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0001, FL_AND, 1'b0, 3'd0, 16'h0);
    check_rf(3'd7, 16'h0001);

    issue(4'b1110, 3'd3, 3'd1, 3'd2, 1'b1, 16'h0001, FL_AND, 1'b0, 3'd0, 16'h0);
    check_rf(3'd3, 16'h8000);

    issue(4'b1000, 3'd1, 3'd2, 3'd2, 1'b0, 16'h000A, 4'b0000, 1'b1, 3'd2, 16'h0005);
    check_rf(3'd1, 16'h000A);
    check_rf(3'd2, 16'h0005);

    // Reset while an ADD is in flight: nothing may retire.
    @(negedge clk);
    instr_op = 4'b1000; instr_dst = 3'd3; instr_srca = 3'd1; instr_srcb = 3'd2;
    instr_valid = 1'b1;
    #1 chk("ready_before_abort", {15'd0, instr_ready}, 16'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_done", {14'd0, done, err}, 16'd0);
    chk("abort_flags", {12'd0, flag_v, flag_c, flag_n, flag_z}, 16'd0);
    chk("abort_done_result", done_result, 16'd0);
    chk("abort_fu", fu_opa | fu_opb | {12'd0, fu_fs}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1 chk($sformatf("abort_rf%0d", i), rd_data, 16'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("post_abort_done", {15'd0, done}, 16'd0);
      chk("post_abort_ready", {15'd0, instr_ready}, 16'd1);
    end

    chk("queue_empty", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
